// File: rtl/time_set_ctrl.sv
// Edit sequencer for clock/alarm time: IDLE -> SET_HH -> SET_MM -> SET_SS -> COMMIT -> IDLE.
// Every output is a register loaded from next-state values, so a button that is sampled at edge k is visible right after edge k.
module time_set_ctrl #(
  parameter int TIMEOUT_S = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        target_sel,
  input  logic        tick_1hz,
  input  logic [16:0] cur_time,
  input  logic [16:0] alarm_time,
  output logic [16:0] disp_time,
  output logic [2:0]  blink_mask,
  output logic        editing,
  output logic [16:0] new_time,
  output logic        load_time,
  output logic        load_alarm
);

  localparam int CW = (TIMEOUT_S < 1) ? 1 : $clog2(TIMEOUT_S + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT_S);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_HH,
    S_SET_MM,
    S_SET_SS,
    S_COMMIT
  } state_t;

  state_t        r_state, w_state_nx;
  logic [16:0]   r_edit, w_edit_nx;
  logic          r_tgt, w_tgt_nx;
  logic [CW-1:0] r_idle_cnt;

  logic [16:0] r_disp, r_new;
  logic [2:0]  r_blink;
  logic        r_editing, r_load_time, r_load_alarm;

  logic [16:0] w_src, w_src_clean;
  logic [4:0]  w_hh;
  logic [5:0]  w_mm, w_ss;
  logic        w_any_btn, w_up, w_dn, w_in_set, w_timeout;

  assign w_src = target_sel ? alarm_time : cur_time;
  assign w_src_clean = {(w_src[16:12] > 5'd23) ? 5'd0 : w_src[16:12],
                        (w_src[11:6]  > 6'd59) ? 6'd0 : w_src[11:6],
                        (w_src[5:0]   > 6'd59) ? 6'd0 : w_src[5:0]};

  assign w_hh = r_edit[16:12];
  assign w_mm = r_edit[11:6];
  assign w_ss = r_edit[5:0];

  // mode beats up/down, and up+down together cancel out
  assign w_any_btn = btn_mode | btn_up | btn_down;
  assign w_up      = btn_up & ~btn_down & ~btn_mode;
  assign w_dn      = btn_down & ~btn_up & ~btn_mode;
  assign w_in_set  = (r_state == S_SET_HH) || (r_state == S_SET_MM) || (r_state == S_SET_SS);
  assign w_timeout = w_in_set && (r_idle_cnt == TO_CNT) && !w_any_btn;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_edit  <= '0;
      r_tgt   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_edit  <= w_edit_nx;
      r_tgt   <= w_tgt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_edit_nx  = r_edit;
    w_tgt_nx   = r_tgt;
    case (r_state)
      S_IDLE: begin
        if (btn_mode) begin
          w_state_nx = S_SET_HH;
          w_tgt_nx   = target_sel;
          w_edit_nx  = w_src_clean;
        end
      end
      S_SET_HH: begin
        if (btn_mode)       w_state_nx = S_SET_MM;
        else if (w_timeout) w_state_nx = S_IDLE;
        else if (w_up)      w_edit_nx[16:12] = (w_hh == 5'd23) ? 5'd0 : w_hh + 5'd1;
        else if (w_dn)      w_edit_nx[16:12] = (w_hh == 5'd0) ? 5'd23 : w_hh - 5'd1;
      end
      S_SET_MM: begin
        if (btn_mode)       w_state_nx = S_SET_SS;
        else if (w_timeout) w_state_nx = S_IDLE;
        else if (w_up)      w_edit_nx[11:6] = (w_mm == 6'd59) ? 6'd0 : w_mm + 6'd1;
        else if (w_dn)      w_edit_nx[11:6] = (w_mm == 6'd0) ? 6'd59 : w_mm - 6'd1;
      end
      S_SET_SS: begin
        if (btn_mode)       w_state_nx = S_COMMIT;
        else if (w_timeout) w_state_nx = S_IDLE;
        else if (w_up)      w_edit_nx[5:0] = (w_ss == 6'd59) ? 6'd0 : w_ss + 6'd1;
        else if (w_dn)      w_edit_nx[5:0] = (w_ss == 6'd0) ? 6'd59 : w_ss - 6'd1;
      end
      S_COMMIT: w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  // Inactivity counter saturates at TIMEOUT_S; the abandon happens on the edge after it gets there
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle_cnt <= '0;
    end else if (!w_in_set || w_any_btn) begin
      r_idle_cnt <= '0;
    end else if (tick_1hz && (r_idle_cnt != TO_CNT)) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp       <= '0;
      r_new        <= '0;
      r_blink      <= 3'b000;
      r_editing    <= 1'b0;
      r_load_time  <= 1'b0;
      r_load_alarm <= 1'b0;
    end else begin
      r_disp       <= (w_state_nx == S_IDLE) ? w_src : w_edit_nx;
      r_blink      <= {w_state_nx == S_SET_HH, w_state_nx == S_SET_MM, w_state_nx == S_SET_SS};
      r_editing    <= (w_state_nx == S_SET_HH) || (w_state_nx == S_SET_MM) ||
                      (w_state_nx == S_SET_SS);
      r_load_time  <= (w_state_nx == S_COMMIT) && !w_tgt_nx;
      r_load_alarm <= (w_state_nx == S_COMMIT) && w_tgt_nx;
      if (w_state_nx == S_COMMIT) r_new <= w_edit_nx;
    end
  end

  assign disp_time  = r_disp;
  assign blink_mask = r_blink;
  assign editing    = r_editing;
  assign new_time   = r_new;
  assign load_time  = r_load_time;
  assign load_alarm = r_load_alarm;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: each task drives one scenario and checks hand-computed values.
module tb_time_set_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        btn_mode, btn_up, btn_down, target_sel, tick_1hz;
  logic [16:0] cur_time, alarm_time, disp_time, new_time;
  logic [2:0]  blink_mask;
  logic        editing, load_time, load_alarm;

  int checks = 0;
  int failures = 0;
  int n_lt = 0;
  int n_la = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(.TIMEOUT_S(10)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .target_sel(target_sel), .tick_1hz(tick_1hz), .cur_time(cur_time), .alarm_time(alarm_time),
    .disp_time(disp_time), .blink_mask(blink_mask), .editing(editing), .new_time(new_time),
    .load_time(load_time), .load_alarm(load_alarm)
  );

  always @(negedge clk) begin
    if (load_time)  n_lt++;
    if (load_alarm) n_la++;
  end

  function automatic logic [16:0] tw(input int h, input int m, input int s);
    return {h[4:0], m[5:0], s[5:0]};
  endfunction

  task automatic press(input logic m, input logic u, input logic d, input logic k);
    @(negedge clk);
    btn_mode = m; btn_up = u; btn_down = d; tick_1hz = k;
    @(negedge clk);
    btn_mode = 0; btn_up = 0; btn_down = 0; tick_1hz = 0;
  endtask

  task automatic test_reset();
    reset = 1; btn_mode = 0; btn_up = 0; btn_down = 0; tick_1hz = 0;
    target_sel = 0; cur_time = tw(13, 45, 30); alarm_time = tw(6, 30, 0);
    repeat (3) @(negedge clk);
    checks++; if (disp_time !== 17'd0) begin failures++; $display("FAIL reset_disp got %h exp %h", disp_time, 17'd0); end
    checks++; if (blink_mask !== 3'b000) begin failures++; $display("FAIL reset_blink got %b exp 000", blink_mask); end
    checks++; if (editing !== 1'b0) begin failures++; $display("FAIL reset_editing got %b exp 0", editing); end
    checks++; if (new_time !== 17'd0) begin failures++; $display("FAIL reset_new_time got %h exp 0", new_time); end
    checks++; if ({load_time, load_alarm} !== 2'b00) begin failures++; $display("FAIL reset_loads got %b exp 00", {load_time, load_alarm}); end
    reset = 0;
    @(negedge clk);
    checks++; if (disp_time !== tw(13, 45, 30)) begin failures++; $display("FAIL idle_follow got %h exp %h", disp_time, tw(13, 45, 30)); end
  endtask

  task automatic test_clock_edit();
    int b_lt, b_la;
    b_lt = n_lt; b_la = n_la;
    target_sel = 0; cur_time = tw(13, 45, 30);
    press(1, 0, 0, 0);
    checks++; if (blink_mask !== 3'b100 || editing !== 1'b1) begin failures++; $display("FAIL edit_hh_state got blink=%b ed=%b exp 100/1", blink_mask, editing); end
    cur_time = tw(2, 2, 2);
    repeat (11) press(0, 1, 0, 0);
    checks++; if (disp_time !== tw(0, 45, 30)) begin failures++; $display("FAIL edit_hh_wrap got %h exp %h", disp_time, tw(0, 45, 30)); end
    press(1, 0, 0, 0);
    checks++; if (blink_mask !== 3'b010) begin failures++; $display("FAIL edit_mm_blink got %b exp 010", blink_mask); end
    press(0, 0, 1, 0);
    checks++; if (disp_time !== tw(0, 44, 30)) begin failures++; $display("FAIL edit_mm_down got %h exp %h", disp_time, tw(0, 44, 30)); end
    press(1, 0, 0, 0);
    checks++; if (blink_mask !== 3'b001) begin failures++; $display("FAIL edit_ss_blink got %b exp 001", blink_mask); end
    press(1, 0, 0, 0);
    checks++; if (load_time !== 1'b1 || load_alarm !== 1'b0) begin failures++; $display("FAIL commit_strobe got lt=%b la=%b exp 1/0", load_time, load_alarm); end
    checks++; if (new_time !== tw(0, 44, 30)) begin failures++; $display("FAIL commit_value got %h exp %h", new_time, tw(0, 44, 30)); end
    checks++; if (blink_mask !== 3'b000 || disp_time !== tw(0, 44, 30)) begin failures++; $display("FAIL commit_disp got blink=%b disp=%h exp 000/%h", blink_mask, disp_time, tw(0, 44, 30)); end
    @(negedge clk);
    checks++; if (load_time !== 1'b0 || editing !== 1'b0 || disp_time !== tw(2, 2, 2)) begin failures++; $display("FAIL post_commit got lt=%b ed=%b disp=%h exp 0/0/%h", load_time, editing, disp_time, tw(2, 2, 2)); end
    #1;
    checks++; if (n_lt - b_lt !== 1 || n_la - b_la !== 0) begin failures++; $display("FAIL clock_strobe_count got lt=%0d la=%0d exp 1/0", n_lt - b_lt, n_la - b_la); end
  endtask

  task automatic test_wrap();
    target_sel = 1; alarm_time = tw(0, 0, 59);
    @(negedge clk);
    checks++; if (disp_time !== tw(0, 0, 59)) begin failures++; $display("FAIL idle_alarm_src got %h exp %h", disp_time, tw(0, 0, 59)); end
    press(1, 0, 0, 0); press(0, 0, 1, 0);
    press(1, 0, 0, 0); press(0, 0, 1, 0);
    press(1, 0, 0, 0); press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    checks++; if (load_alarm !== 1'b1 || load_time !== 1'b0) begin failures++; $display("FAIL wrap_strobe got lt=%b la=%b exp 0/1", load_time, load_alarm); end
    checks++; if (new_time !== tw(23, 59, 0)) begin failures++; $display("FAIL wrap_value got %h exp %h", new_time, tw(23, 59, 0)); end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int b_lt, b_la;
    target_sel = 0; cur_time = tw(12, 0, 0);
    @(negedge clk);
    b_lt = n_lt; b_la = n_la;
    press(1, 0, 0, 0);
    repeat (9) press(0, 0, 0, 1);
    repeat (3) @(negedge clk);
    checks++; if (editing !== 1'b1) begin failures++; $display("FAIL timeout_9_ticks got ed=%b exp 1", editing); end
    press(0, 1, 0, 0);
    checks++; if (disp_time !== tw(13, 0, 0)) begin failures++; $display("FAIL timeout_up got %h exp %h", disp_time, tw(13, 0, 0)); end
    repeat (9) press(0, 0, 0, 1);
    repeat (3) @(negedge clk);
    checks++; if (editing !== 1'b1) begin failures++; $display("FAIL timeout_cleared_by_btn got ed=%b exp 1", editing); end
    press(0, 0, 0, 1);
    repeat (2) @(negedge clk);
    checks++; if (editing !== 1'b0 || blink_mask !== 3'b000) begin failures++; $display("FAIL timeout_idle got ed=%b blink=%b exp 0/000", editing, blink_mask); end
    checks++; if (disp_time !== tw(12, 0, 0)) begin failures++; $display("FAIL timeout_disp got %h exp %h", disp_time, tw(12, 0, 0)); end
    cur_time = tw(12, 0, 5);
    @(negedge clk);
    checks++; if (disp_time !== tw(12, 0, 5)) begin failures++; $display("FAIL timeout_track got %h exp %h", disp_time, tw(12, 0, 5)); end
    #1;
    checks++; if (n_lt - b_lt !== 0 || n_la - b_la !== 0) begin failures++; $display("FAIL timeout_no_strobe got lt=%0d la=%0d exp 0/0", n_lt - b_lt, n_la - b_la); end
  endtask

  task automatic test_conflicts();
    target_sel = 0; cur_time = tw(10, 20, 30); alarm_time = tw(1, 2, 3);
    @(negedge clk);
    press(1, 0, 0, 0);
    press(1, 1, 0, 0);
    checks++; if (blink_mask !== 3'b010 || disp_time !== tw(10, 20, 30)) begin failures++; $display("FAIL mode_up_conflict got blink=%b disp=%h exp 010/%h", blink_mask, disp_time, tw(10, 20, 30)); end
    press(0, 1, 1, 0);
    checks++; if (blink_mask !== 3'b010 || disp_time !== tw(10, 20, 30)) begin failures++; $display("FAIL up_down_conflict got blink=%b disp=%h exp 010/%h", blink_mask, disp_time, tw(10, 20, 30)); end
    target_sel = 1;
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    checks++; if (load_time !== 1'b1 || load_alarm !== 1'b0) begin failures++; $display("FAIL latched_target got lt=%b la=%b exp 1/0", load_time, load_alarm); end
    checks++; if (new_time !== tw(10, 20, 30)) begin failures++; $display("FAIL conflict_value got %h exp %h", new_time, tw(10, 20, 30)); end
    @(negedge clk);
    target_sel = 0;
  endtask

  task automatic test_reset_mid();
    int b_lt, b_la;
    target_sel = 0; cur_time = tw(5, 6, 7);
    @(negedge clk);
    b_lt = n_lt; b_la = n_la;
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(0, 1, 0, 0);
    checks++; if (blink_mask !== 3'b010 || disp_time !== tw(5, 7, 7)) begin failures++; $display("FAIL pre_reset_mm got blink=%b disp=%h exp 010/%h", blink_mask, disp_time, tw(5, 7, 7)); end
    @(negedge clk);
    reset = 1;
    #1;
    checks++; if (disp_time !== 17'd0 || blink_mask !== 3'b000 || editing !== 1'b0 || new_time !== 17'd0) begin failures++; $display("FAIL mid_reset_outputs got disp=%h blink=%b ed=%b new=%h exp 0", disp_time, blink_mask, editing, new_time); end
    repeat (2) @(negedge clk);
    reset = 0;
    press(1, 0, 0, 0);
    checks++; if (blink_mask !== 3'b100) begin failures++; $display("FAIL post_reset_restart got blink=%b exp 100", blink_mask); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (n_lt - b_lt !== 0 || n_la - b_la !== 0) begin failures++; $display("FAIL mid_reset_no_strobe got lt=%0d la=%0d exp 0/0", n_lt - b_lt, n_la - b_la); end
    reset = 1;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_invalid_capture();
    logic [16:0] bad;
    bad = {5'd25, 6'd61, 6'd7};
    target_sel = 0; cur_time = bad;
    @(negedge clk);
    press(1, 0, 0, 0);
    checks++; if (disp_time !== tw(0, 0, 7)) begin failures++; $display("FAIL invalid_capture got %h exp %h", disp_time, tw(0, 0, 7)); end
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(1, 0, 0, 0);
    checks++; if (load_time !== 1'b1 || new_time !== tw(0, 0, 7)) begin failures++; $display("FAIL invalid_commit got lt=%b new=%h exp 1/%h", load_time, new_time, tw(0, 0, 7)); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    target_sel = 0; cur_time = tw(20, 10, 5);
    @(negedge clk);
    btn_mode = 1;
    @(negedge clk);
    btn_mode = 0; btn_up = 1;
    repeat (3) @(negedge clk);
    btn_up = 0;
    checks++; if (disp_time !== tw(23, 10, 5) || blink_mask !== 3'b100) begin failures++; $display("FAIL b2b_up got disp=%h blink=%b exp %h/100", disp_time, blink_mask, tw(23, 10, 5)); end
    btn_mode = 1;
    repeat (3) @(negedge clk);
    btn_mode = 0;
    checks++; if (load_time !== 1'b1 || new_time !== tw(23, 10, 5)) begin failures++; $display("FAIL b2b_commit got lt=%b new=%h exp 1/%h", load_time, new_time, tw(23, 10, 5)); end
    @(negedge clk);
    checks++; if (load_time !== 1'b0 || editing !== 1'b0) begin failures++; $display("FAIL b2b_idle got lt=%b ed=%b exp 0/0", load_time, editing); end
  endtask

  initial begin
    test_reset();
    test_clock_edit();
    test_wrap();
    test_timeout();
    test_conflicts();
    test_reset_mid();
    test_invalid_capture();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Edit sequencer for the alarm clock's time and alarm registers. It sits between the debounced pushbuttons and the 17-bit time path that feeds mode12_24. In normal running it forwards the selected live time. On request it walks the user through hours, minutes and seconds, then commits the edited value to the timekeeper or to the alarm register with a one-cycle load strobe.

## Interface
Time word format used on every 17-bit port: [16:12] hours 0–23, [11:6] minutes 0–59, [5:0] seconds 0–59, 24h binary.

Parameters:
- TIMEOUT_S, 10, number of whole tick_1hz periods without a button press after which an edit is abandoned.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_mode  in  1  debounced one-cycle pulse; start, advance or commit an edit
- btn_up  in  1  debounced one-cycle pulse; increment the field being edited
- btn_down  in  1  debounced one-cycle pulse; decrement the field being edited
- target_sel  in  1  0 = clock time, 1 = alarm time
- tick_1hz  in  1  one-cycle pulse once per second
- cur_time  in  17  live timekeeper value
- alarm_time  in  17  stored alarm value
- disp_time  out  17  registered time sent to mode12_24
- blink_mask  out  3  one-hot field being edited: [2] = HH, [1] = MM, [0] = SS
- editing  out  1  high in every SET state
- new_time  out  17  edited value; valid while a load strobe is high
- load_time  out  1  one-cycle commit strobe to the timekeeper
- load_alarm  out  1  one-cycle commit strobe to the alarm register

## Operation
- States: IDLE, SET_HH, SET_MM, SET_SS, COMMIT.
- **IDLE**
  - disp_time follows (target_sel ? alarm_time : cur_time).
  - btn_mode latches target_sel into an internal edit_tgt bit, copies the selected source into edit_reg, and moves to SET_HH.
  - On that capture, any field above its maximum (hours > 23, min/sec > 59) is loaded as 0.
- **SET_HH**
  - btn_up: hours = (hours + 1) mod 24. btn_down: hours = (hours + 23) mod 24.
  - btn_mode moves to SET_MM.
- **SET_MM**
  - Same rules on minutes, mod 60 (down from 0 gives 59).
  - btn_mode moves to SET_SS.
- **SET_SS**
  - Same rules on seconds, mod 60.
  - btn_mode moves to COMMIT.
- **COMMIT** lasts exactly one cycle:
  - new_time = edit_reg.
  - load_time = ~edit_tgt, load_alarm = edit_tgt.
  - Then returns to IDLE.
- **Display during edits**
  - In the SET states and COMMIT, disp_time = edit_reg.
  - Other fields are not changed by an edit, and the live source is ignored.
- **Timeout**
  - An idle counter clears on any button pulse and on entry to SET_HH. It increments on tick_1hz while in a SET state.
  - When the count reaches TIMEOUT_S, the FSM returns to IDLE with no load strobe.
  - Counter width is ceil(log2(TIMEOUT_S + 1)), and the counter saturates.
- **Simultaneous events**
  - btn_up and btn_down in the same cycle: both are ignored. The idle counter is still cleared.
  - btn_mode together with up or down: btn_mode wins and the field is not changed.
  - Timeout reached in the same cycle as a button press: the button wins and the counter clears.
- target_sel changes during an edit are ignored until the FSM is back in IDLE.
- Only one of load_time and load_alarm is ever high, and neither is high outside COMMIT.

## Timing
- **Reset values:** state IDLE; edit_reg, new_time and disp_time all 0; blink_mask 000; editing, load_time and load_alarm all 0.
- A reset asserted mid-edit abandons the edit with no strobe.
- All outputs are registered. A button sampled at edge k takes effect from edge k, i.e. it is visible in the cycle after k.
- **disp_time latency in IDLE:** 1 cycle from cur_time or alarm_time.
- **blink_mask** = 100, 010, 001 in SET_HH, SET_MM, SET_SS respectively; 000 in IDLE and COMMIT. editing follows the same states.
- **Commit timing:** btn_mode in SET_SS at edge k puts COMMIT, its strobe and new_time in the cycle after k. IDLE follows at edge k+1.
- **Minimum full edit:** 4 btn_mode pulses. Button pulses in consecutive cycles are all honoured.

## Test plan
- **Clock edit.** Reset; cur_time = 13:45:30, target_sel = 0.
  - Sequence: mode, up ×11, mode, down, mode, mode.
  - Required: blink_mask steps 100 → 010 → 001 → 000.
  - Required: a single load_time pulse with new_time = 00:44:30; load_alarm stays 0.
- **Wrap-around.** Alarm edit starting from 00:00:59.
  - Sequence: mode, down, mode, down, mode, up, mode.
  - Required: load_alarm with new_time = 23:59:00.
- **Timeout.** TIMEOUT_S = 10.
  - Sequence: mode, then 9 ticks, up, 10 ticks.
  - Required: still in edit after the 9th tick.
  - Required: IDLE and no strobe after the 10th tick following the up; disp_time tracks cur_time again.
- **Conflicts.**
  - up + down together in SET_MM: minutes unchanged.
  - mode + up together in SET_HH: goes to SET_MM with hours unchanged.
  - target_sel toggled mid-edit: the strobe still goes to the originally latched target.
- **Reset mid-edit and invalid capture.**
  - Reset asserted during SET_MM: all outputs at reset values on the same edge; no strobe afterwards.
  - Starting an edit from 25:61:07: edit_reg captures 00:00:07.
